// File: rtl/big_deserialize_pkg.sv
// Shared definitions for the dual-lane deserializer: FSM encoding and IDLE word halves.
package big_deserialize_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] IDLE_HI_DEF = 16'hF0A5;
  localparam logic [15:0] IDLE_LO_DEF = 16'h0F5A;
  localparam int          BIT_POS_W   = 4;

endpackage

// File: rtl/big_deserialize_lane.sv
// One serial lane: 16-bit MSB-first shift register; outputs the post-shift
// window and whether it matches this lane's IDLE half.
module deser_lane #(
  parameter logic [15:0] IDLE_HALF = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        din_i,
  output logic [15:0] sr_o,
  output logic        hit_o
);

  logic [14:0] sr_q;
  logic [15:0] sr_d;

  // Only 15 bits are stored; the 16th is the bit arriving this cycle.
  assign sr_d  = {sr_q, din_i};
  assign sr_o  = sr_d;
  assign hit_o = (sr_d == IDLE_HALF);

  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d[14:0];
    end
  end

endmodule

// File: rtl/big_deserialize.sv
// Two-lane serial receiver: aligns on IDLE words, rebuilds 32-bit words and
// strobes each non-IDLE word one cycle after its last bit.
module big_deserialize
  import big_deserialize_pkg::*;
#(
  parameter logic [15:0] IDLE_HI  = IDLE_HI_DEF,
  parameter logic [15:0] IDLE_LO  = IDLE_LO_DEF,
  parameter int          LOCK_CNT = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             out_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync,
  input  logic             din1,
  input  logic             din2,
  output logic [31:0]      data_out,
  output logic             data_valid,
  output logic             locked,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  logic [15:0]          sr1, sr2;
  logic                 hit1, hit2, idle_hit, boundary;
  state_t               state_q;
  logic [BIT_POS_W-1:0] bit_pos_q;
  logic [3:0]           match_q, match_inc;
  logic [31:0]          dout_q;
  logic                 vld_q, lock_q;
  logic [CNT_W-1:0]     cnt_q;

  deser_lane #(.IDLE_HALF(IDLE_HI)) u_lane1 (
    .clk_i(out_clk), .reset_i(reset), .enable_i(enable), .din_i(din1),
    .sr_o(sr1), .hit_o(hit1)
  );

  deser_lane #(.IDLE_HALF(IDLE_LO)) u_lane2 (
    .clk_i(out_clk), .reset_i(reset), .enable_i(enable), .din_i(din2),
    .sr_o(sr2), .hit_o(hit2)
  );

  assign idle_hit  = hit1 && hit2;
  assign boundary  = &bit_pos_q;
  assign match_inc = match_q + 4'd1;

  always_ff @(posedge out_clk) begin
    if (reset) begin
      state_q   <= HUNT;
      bit_pos_q <= '0;
      match_q   <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
    end else if (!enable || resync) begin
      // data_out and word_cnt deliberately survive a loss of lock
      state_q   <= HUNT;
      bit_pos_q <= '0;
      match_q   <= '0;
      vld_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      vld_q     <= 1'b0;
      bit_pos_q <= bit_pos_q + BIT_POS_W'(1);
      case (state_q)
        HUNT: begin
          if (idle_hit) begin
            bit_pos_q <= '0;
            match_q   <= 4'd1;
            if (LOCK_CNT == 1) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
            end else begin
              state_q <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (idle_hit) begin
              match_q <= match_inc;
              if (match_inc == LOCK_N) begin
                state_q <= LOCKED;
                lock_q  <= 1'b1;
              end
            end else begin
              state_q <= HUNT;
              match_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (boundary && !idle_hit) begin
            dout_q <= {sr1, sr2};
            vld_q  <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= HUNT;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = vld_q;
  assign locked     = lock_q;
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_big_deserialize.sv
// Directed bench for big_deserialize: table-driven word stream plus hand-written
// resync, enable-drop and counter-saturation sequences.
module tb_big_deserialize;

  localparam int CNT_W = 5;  // narrow counter so saturation is reachable quickly
  localparam logic [31:0] IDLE = 32'hF0A5_0F5A;

  logic             clk = 1'b0;
  logic             reset, enable, resync, din1, din2;
  logic [31:0]      data_out;
  logic             data_valid, locked;
  logic [CNT_W-1:0] word_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int strobes = 0;
  int exp_strobes = 0;

  typedef struct {
    logic [31:0] w;
    logic        vld;
    logic        lock;
    logic [31:0] dout;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[19];

  big_deserialize #(
    .IDLE_HI(16'hF0A5), .IDLE_LO(16'h0F5A), .LOCK_CNT(4), .CNT_W(CNT_W)
  ) dut (
    .out_clk(clk), .reset(reset), .enable(enable), .resync(resync),
    .din1(din1), .din2(din2), .data_out(data_out), .data_valid(data_valid),
    .locked(locked), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_valid === 1'b1) strobes++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic lock,
                           input logic [31:0] dout, input int cnt);
    chk({tag, "_vld"},  32'(data_valid), 32'(vld));
    chk({tag, "_lock"}, 32'(locked),     32'(lock));
    chk({tag, "_dout"}, data_out,        dout);
    chk({tag, "_cnt"},  32'(word_cnt),   32'(cnt));
    if (vld) exp_strobes++;
  endtask

  // Drives 16 bits per lane MSB first; returns #1 after the edge that samples the last bit.
  task automatic send_word(input logic [31:0] w, input bit rs_last);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      din1   = w[16+i];
      din2   = w[i];
      resync = rs_last && (i == 0);
    end
    @(posedge clk);
    #1;
    resync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    din1 = 1'b0;
    din2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_word(vecs[i].w, 1'b0);
      check_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].lock, vecs[i].dout,
                int'(vecs[i].cnt));
    end
  endtask

  initial begin
    logic [6:0] pre1, pre2;
    logic [31:0] w;
    int c;

    // test 1: lock on 4 IDLE, deliver one word
    vecs[0]  = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[1]  = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[2]  = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[3]  = '{IDLE,         1'b0, 1'b1, 32'h0,         5'd0};
    vecs[4]  = '{32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF,  5'd1};
    vecs[5]  = '{IDLE,         1'b0, 1'b1, 32'hDEADBEEF,  5'd1};
    // test 2: after 7 prefix bits
    vecs[6]  = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[7]  = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[8]  = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[9]  = '{IDLE,         1'b0, 1'b1, 32'h0,         5'd0};
    vecs[10] = '{32'h12345678, 1'b1, 1'b1, 32'h12345678,  5'd1};
    // test 3: 3rd IDLE corrupted in lane 2 bit 5, then 4 clean IDLE
    vecs[11] = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[12] = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[13] = '{32'hF0A50F7A, 1'b0, 1'b0, 32'h0,         5'd0};
    vecs[14] = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[15] = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[16] = '{IDLE,         1'b0, 1'b0, 32'h0,         5'd0};
    vecs[17] = '{IDLE,         1'b0, 1'b1, 32'h0,         5'd0};
    vecs[18] = '{32'h11112222, 1'b1, 1'b1, 32'h11112222,  5'd1};

    reset = 1'b1; enable = 1'b1; resync = 1'b0; din1 = 1'b0; din2 = 1'b0;
    do_reset();
    check_out("reset", 1'b0, 1'b0, 32'h0, 0);

    run_vecs(0, 5);

    do_reset();
    pre1 = 7'b1011001;
    pre2 = 7'b0110101;
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      din1 = pre1[i];
      din2 = pre2[i];
    end
    run_vecs(6, 10);

    do_reset();
    run_vecs(11, 18);

    // test 4: resync on the boundary cycle drops the word
    send_word(32'hCAFEF00D, 1'b1);
    check_out("resync", 1'b0, 1'b0, 32'h11112222, 1);
    for (int k = 0; k < 4; k++) begin
      send_word(IDLE, 1'b0);
      check_out($sformatf("relock%0d", k), 1'b0, k == 3, 32'h11112222, 1);
    end

    // test 5: enable low for 5 cycles mid-word
    w = 32'hAAAA5555;
    for (int i = 15; i >= 8; i--) begin
      @(negedge clk);
      din1 = w[16+i];
      din2 = w[i];
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_out("en_low1", 1'b0, 1'b0, 32'h11112222, 1);
    repeat (4) @(posedge clk);
    #1;
    check_out("en_low5", 1'b0, 1'b0, 32'h11112222, 1);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_word(IDLE, 1'b0);
      check_out($sformatf("en_relock%0d", k), 1'b0, k == 3, 32'h11112222, 1);
    end
    send_word(32'h0BADC0DE, 1'b0);
    check_out("en_word", 1'b1, 1'b1, 32'h0BADC0DE, 2);

    // test 6: back-to-back words past counter saturation
    for (int k = 0; k < 33; k++) begin
      w = 32'h5000_0000 + 32'(k);
      c = 3 + k;
      if (c > 31) c = 31;
      send_word(w, 1'b0);
      check_out($sformatf("b2b%0d", k), 1'b1, 1'b1, w, c);
    end

    @(negedge clk);
    #1;
    chk("strobe_total", 32'(strobes), 32'(exp_strobes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
